// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART constants, FSM encoding and the baud divisor clamp.
// Revision : 1.0
// ============================================================================
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Encoding is shared with the receiver so both debug_state views line up.
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP1  = 3'd4;
  localparam logic [2:0] STOP2  = 3'd5;

  typedef struct packed {
    logic [15:0] baud;
    logic [1:0]  par;
    logic        two_stop;
  } tx_cfg_t;

  function automatic logic [15:0] clamp_baud(input logic [15:0] b);
    return (b == 16'd0) ? 16'd1 : b;
  endfunction

  function automatic logic parity_enabled(input logic [1:0] sel);
    return (sel == PAR_EVEN) || (sel == PAR_ODD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_tick
// Purpose  : 16-bit loadable down-counter; ticks while enabled and at zero.
// Revision : 1.0
// ============================================================================
module uart_baud_tick (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [15:0] i_load_val,
  input  logic        i_en,
  output logic        o_tick
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = i_load_val;
    end else if (i_en && (count_q != 16'd0)) begin
      count_d = count_q - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_tick = i_en && (count_q == 16'd0);

endmodule
`default_nettype wire

// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_engine
// Purpose  : UART transmitter with one-entry holding register, LSB first.
// Revision : 1.0
// ============================================================================
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int   DATA_BITS  = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                 mclk,
  input  logic                 reset,
  input  logic [15:0]          baudrate,
  input  logic [1:0]           parity_sel,
  input  logic                 stop_sel,
  input  logic [DATA_BITS-1:0] tdata,
  input  logic                 send,
  output logic                 trdy,
  output logic                 txd,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic [2:0]           state_q,     state_d;
  logic [DATA_BITS-1:0] hold_q,      hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic [IDX_W-1:0]     bit_q,       bit_d;
  tx_cfg_t              cfg_q,       cfg_d;
  logic                 par_bit_q,   par_bit_d;
  logic                 txd_q,       txd_d;
  logic                 tx_done_q,   tx_done_d;

  logic        baud_load;
  logic [15:0] baud_load_val;
  logic        baud_tick;
  logic        start_frame;
  logic        finish_frame;
  logic [15:0] new_baud;

  assign new_baud = clamp_baud(baudrate);

  uart_baud_tick u_baud_tick (
    .clk        (mclk),
    .rst        (reset),
    .i_load     (baud_load),
    .i_load_val (baud_load_val),
    .i_en       (busy),
    .o_tick     (baud_tick)
  );

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    shift_d       = shift_q;
    bit_d         = bit_q;
    cfg_d         = cfg_q;
    par_bit_d     = par_bit_q;
    tx_done_d     = 1'b0;
    baud_load     = 1'b0;
    baud_load_val = cfg_q.baud - 16'd1;
    start_frame   = 1'b0;
    finish_frame  = 1'b0;

    case (state_q)
      IDLE: begin
        start_frame = hold_full_q;
      end
      START: begin
        if (baud_tick) begin
          state_d   = DATA;
          bit_d     = '0;
          baud_load = 1'b1;
        end
      end
      DATA: begin
        if (baud_tick) begin
          shift_d   = shift_q >> 1;
          baud_load = 1'b1;
          if (bit_q == LAST_IDX) begin
            state_d = parity_enabled(cfg_q.par) ? PARITY : STOP1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          state_d   = STOP1;
          baud_load = 1'b1;
        end
      end
      STOP1: begin
        if (baud_tick) begin
          if (cfg_q.two_stop) begin
            state_d   = STOP2;
            baud_load = 1'b1;
          end else begin
            finish_frame = 1'b1;
          end
        end
      end
      STOP2: begin
        finish_frame = baud_tick;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A queued byte chains straight into START with no idle cycle.
    if (finish_frame) begin
      tx_done_d   = 1'b1;
      start_frame = hold_full_q;
      if (!hold_full_q) begin
        state_d = IDLE;
      end
    end

    if (start_frame) begin
      state_d       = START;
      shift_d       = hold_q;
      hold_full_d   = 1'b0;
      cfg_d         = '{baud: new_baud, par: parity_sel, two_stop: stop_sel};
      par_bit_d     = (^hold_q) ^ (parity_sel == PAR_ODD);
      baud_load     = 1'b1;
      baud_load_val = new_baud - 16'd1;
    end

    if (send && !hold_full_q) begin
      hold_d      = tdata;
      hold_full_d = 1'b1;
    end
  end

  // txd follows the registered state, so the line lags the FSM by one cycle.
  always_comb begin
    txd_d = IDLE_LEVEL;
    case (state_q)
      START:   txd_d = ~IDLE_LEVEL;
      DATA:    txd_d = shift_q[0];
      PARITY:  txd_d = par_bit_q;
      default: txd_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_q       <= '0;
      cfg_q       <= '{baud: 16'd1, par: PAR_NONE, two_stop: 1'b0};
      par_bit_q   <= 1'b0;
      txd_q       <= IDLE_LEVEL;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      cfg_q       <= cfg_d;
      par_bit_q   <= par_bit_d;
      txd_q       <= txd_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign trdy    = ~hold_full_q;
  assign busy    = (state_q != IDLE);
  assign txd     = txd_q;
  assign tx_done = tx_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_engine
// Purpose  : Directed self-checking bench for uart_tx_engine.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_engine;

  logic        mclk;
  logic        reset;
  logic [15:0] baudrate;
  logic [1:0]  parity_sel;
  logic        stop_sel;
  logic [7:0]  tdata;
  logic        send;
  logic        trdy;
  logic        txd;
  logic        busy;
  logic        tx_done;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_engine #(
    .DATA_BITS  (8),
    .IDLE_LEVEL (1'b1)
  ) dut (
    .mclk       (mclk),
    .reset      (reset),
    .baudrate   (baudrate),
    .parity_sel (parity_sel),
    .stop_sel   (stop_sel),
    .tdata      (tdata),
    .send       (send),
    .trdy       (trdy),
    .txd        (txd),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one byte from idle and check the two cycles before the start bit.
  task automatic start_byte(input logic [7:0] d);
    @(negedge mclk);
    send  = 1'b1;
    tdata = d;
    @(negedge mclk);
    send = 1'b0;
    chk("trdy_after_accept", trdy, 1'b0);
    chk("txd_pre1", txd, 1'b1);
    @(negedge mclk);
    chk("trdy_after_xfer", trdy, 1'b1);
    chk("busy_pre2", busy, 1'b1);
    chk("txd_pre2", txd, 1'b1);
  endtask

  // Walk one frame cycle by cycle. exp_par is the hand-computed parity bit.
  task automatic check_frame(input string tag, input logic [7:0] d, input int b,
                             input logic has_par, input logic exp_par, input logic two_stop,
                             input logic b2b, input logic chg_baud, input logic queue_aa);
    logic bits [0:11];
    int   nb;
    logic last;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    nb = 9;
    if (has_par) begin
      bits[nb] = exp_par;
      nb++;
    end
    bits[nb] = 1'b1;
    nb++;
    if (two_stop) begin
      bits[nb] = 1'b1;
      nb++;
    end
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < b; c++) begin
        @(negedge mclk);
        if (chg_baud && k == 2 && c == 0) baudrate = 16'd7;
        if (queue_aa && k == 3 && c == 0) begin
          send  = 1'b1;
          tdata = 8'hAA;
        end
        if (queue_aa && k == 3 && c == 1) begin
          send = 1'b0;
          chk({tag, "_trdy_queued"}, trdy, 1'b0);
        end
        if (queue_aa && k == 5 && c == 0) begin
          send  = 1'b1;
          tdata = 8'h33;
        end
        if (queue_aa && k == 5 && c == 1) begin
          send = 1'b0;
          chk({tag, "_trdy_drop"}, trdy, 1'b0);
        end
        last = (k == nb - 1) && (c == b - 1);
        chk($sformatf("%s_txd_b%0d_c%0d", tag, k, c), txd, bits[k]);
        chk($sformatf("%s_done_b%0d_c%0d", tag, k, c), tx_done, last);
        chk($sformatf("%s_busy_b%0d_c%0d", tag, k, c), busy, !last || b2b);
      end
    end
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    int lows;
    int dones;
    lows  = 0;
    dones = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge mclk);
      if (txd !== 1'b1) lows++;
      if (tx_done !== 1'b0) dones++;
    end
    chk({tag, "_txd_lows"}, 16'(lows), 16'd0);
    chk({tag, "_dones"}, 16'(dones), 16'd0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_trdy"}, trdy, 1'b1);
  endtask

  initial begin
    reset      = 1'b1;
    send       = 1'b0;
    tdata      = 8'h00;
    baudrate   = 16'd4;
    parity_sel = 2'b00;
    stop_sel   = 1'b0;

    @(negedge mclk);
    chk("rst_txd", txd, 1'b1);
    chk("rst_trdy", trdy, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    reset = 1'b0;

    // A5, B=4, no parity, one stop: 40-cycle frame.
    start_byte(8'hA5);
    check_frame("a5", 8'hA5, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_quiet("a5_idle", 3);

    // 07, B=2, even parity -> 1; then odd parity -> 0. 22 cycles each.
    baudrate   = 16'd2;
    parity_sel = 2'b01;
    start_byte(8'h07);
    check_frame("even07", 8'h07, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    parity_sel = 2'b10;
    start_byte(8'h07);
    check_frame("odd07", 8'h07, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 00, B=3, odd parity -> 1, two stop bits: 36 cycles.
    baudrate   = 16'd3;
    stop_sel   = 1'b1;
    start_byte(8'h00);
    check_frame("odd00", 8'h00, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Back-to-back 55 then AA at B=2; a third send while full is dropped.
    baudrate   = 16'd2;
    parity_sel = 2'b00;
    stop_sel   = 1'b0;
    start_byte(8'h55);
    check_frame("b2b55", 8'h55, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_frame("b2bAA", 8'hAA, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_quiet("b2b_idle", 6);

    // Reset during data bit 3 of FF at B=2 (start + bits 0..2 = 8 cycles).
    start_byte(8'hFF);
    repeat (9) @(negedge mclk);
    chk("mid_txd_data3", txd, 1'b1);
    chk("mid_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge mclk);
    chk("abort_txd", txd, 1'b1);
    chk("abort_trdy", trdy, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", tx_done, 1'b0);
    reset = 1'b0;
    check_quiet("abort_idle", 30);
    start_byte(8'h3C);
    check_frame("after_rst", 8'h3C, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // baudrate=0 behaves as 1; mid-frame change to 7 has no effect.
    baudrate = 16'd0;
    start_byte(8'h81);
    check_frame("b0", 8'h81, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_quiet("b0_idle", 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
